// File: rtl/eth_tx_framer_if.sv
// Valid/ready byte stream from the MAC client into the RMII transmit framer.
interface eth_tx_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/eth_tx_framer.sv
// RMII 100 Mb/s transmit framer: preamble/SFD, payload, zero pad to 60 bytes,
// CRC-32 FCS and inter-packet gap, one dibit per clk.
module eth_tx_framer (
  input  logic                  clk,
  input  logic                  rst,
  eth_tx_framer_if.slave        tx,
  output logic [1:0]            rmii_txd,
  output logic                  rmii_txen,
  output logic                  busy,
  output logic                  underrun
);

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned NBYTES_W = 6;
  localparam int unsigned FCS_W    = 32;

  localparam logic [CNT_W-1:0]    PRE_LAST  = CNT_W'(31);
  localparam logic [CNT_W-1:0]    FCS_LAST  = CNT_W'(15);
  localparam logic [CNT_W-1:0]    IFG_LAST  = CNT_W'(47);
  localparam logic [NBYTES_W-1:0] MIN_BYTES = NBYTES_W'(60);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [1:0]          idx, idx_n;
  logic [NBYTES_W-1:0] nbytes, nbytes_n;
  logic [7:0]          sreg, sreg_n;
  logic [FCS_W-1:0]    fcs, fcs_n;
  logic                last_q, last_n;
  logic                crc_clr, crc_clr_n;

  logic                tx_ready_n;
  logic [1:0]          txd_n;
  logic                txen_n;
  logic                busy_n;
  logic                underrun_n;
  logic                accept;

  logic                crc_en;
  logic                crc_rst;
  logic [FCS_W-1:0]    crc_out;

  // CRC sees exactly the dibits on the wire while payload/pad are sent.
  assign crc_en  = (state == S_DATA) || (state == S_PAD);
  assign crc_rst = rst | crc_clr;

  crc_gen u_crc (
    .clk     (clk),
    .rst     (crc_rst),
    .en      (crc_en),
    .data_in (rmii_txd),
    .crc_out (crc_out)
  );

  // State register plus registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      nbytes      <= '0;
      sreg        <= '0;
      fcs         <= '0;
      last_q      <= 1'b0;
      crc_clr     <= 1'b1;
      tx.tx_ready <= 1'b0;
      rmii_txd    <= 2'b00;
      rmii_txen   <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      nbytes      <= nbytes_n;
      sreg        <= sreg_n;
      fcs         <= fcs_n;
      last_q      <= last_n;
      crc_clr     <= crc_clr_n;
      tx.tx_ready <= tx_ready_n;
      rmii_txd    <= txd_n;
      rmii_txen   <= txen_n;
      busy        <= busy_n;
      underrun    <= underrun_n;
    end
  end

  // Next state; outputs are decoded from the next-state values so they are
  // flops that always reflect the state being entered.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    nbytes_n   = nbytes;
    sreg_n     = sreg;
    fcs_n      = fcs;
    last_n     = last_q;
    underrun_n = 1'b0;
    accept     = tx.tx_valid & tx.tx_ready;

    unique case (state)
      S_IDLE: begin
        if (tx.tx_valid) begin
          state_n = S_PRE;
          cnt_n   = '0;
        end
      end

      S_PRE: begin
        if (cnt != PRE_LAST) begin
          cnt_n = cnt + CNT_W'(1);
        end else if (accept) begin
          state_n  = S_DATA;
          sreg_n   = tx.tx_data;
          last_n   = tx.tx_last;
          nbytes_n = NBYTES_W'(1);
          idx_n    = '0;
        end else begin
          state_n    = S_IFG;
          cnt_n      = '0;
          underrun_n = 1'b1;
        end
      end

      S_DATA: begin
        if (idx != 2'd3) begin
          idx_n = idx + 2'd1;
        end else if (!last_q) begin
          if (accept) begin
            sreg_n = tx.tx_data;
            last_n = tx.tx_last;
            idx_n  = '0;
            if (nbytes < MIN_BYTES) nbytes_n = nbytes + NBYTES_W'(1);
          end else begin
            state_n    = S_IFG;
            cnt_n      = '0;
            underrun_n = 1'b1;
          end
        end else if (nbytes < MIN_BYTES) begin
          state_n  = S_PAD;
          idx_n    = '0;
          nbytes_n = nbytes + NBYTES_W'(1);
        end else begin
          state_n = S_FCS;
          cnt_n   = '0;
          fcs_n   = crc_out;
        end
      end

      S_PAD: begin
        if (idx != 2'd3) begin
          idx_n = idx + 2'd1;
        end else if (nbytes == MIN_BYTES) begin
          state_n = S_FCS;
          cnt_n   = '0;
          fcs_n   = crc_out;
        end else begin
          idx_n    = '0;
          nbytes_n = nbytes + NBYTES_W'(1);
        end
      end

      S_FCS: begin
        if (cnt == FCS_LAST) begin
          state_n = S_IFG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_IFG: begin
        // The last gap cycle doubles as the first IDLE cycle, so a waiting
        // frame starts with exactly 48 low cycles between frames.
        if (cnt == IFG_LAST) begin
          cnt_n   = '0;
          state_n = tx.tx_valid ? S_PRE : S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    txen_n    = state_n inside {S_PRE, S_DATA, S_PAD, S_FCS};
    busy_n    = (state_n != S_IDLE);
    crc_clr_n = (state_n == S_IDLE) || (state_n == S_IFG);

    tx_ready_n = ((state_n == S_PRE) && (cnt_n == PRE_LAST)) ||
                 ((state_n == S_DATA) && (idx_n == 2'd3) && !last_n);

    unique case (state_n)
      S_PRE:   txd_n = (cnt_n == PRE_LAST) ? 2'b11 : 2'b01;
      S_DATA:  txd_n = sreg_n[{idx_n, 1'b0} +: 2];
      S_FCS:   txd_n = fcs_n[{cnt_n[3:0], 1'b0} +: 2];
      default: txd_n = 2'b00;
    endcase
  end

endmodule

// Reflected CRC-32 (poly 0xEDB88320) over dibits, bit 0 first; crc_out is the
// complemented FCS including the dibit presented this cycle.
module crc_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  data_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY = 32'hEDB88320;

  logic [31:0] crc_q;
  logic [31:0] crc_nxt;

  // Two serial steps of the reflected LFSR.
  always_comb begin
    crc_nxt = crc_q;
    for (int i = 0; i < 2; i++) begin
      if (crc_nxt[0] ^ data_in[i]) crc_nxt = (crc_nxt >> 1) ^ POLY;
      else                         crc_nxt = crc_nxt >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     crc_q <= '1;
    else if (en) crc_q <= crc_nxt;
  end

  assign crc_out = ~crc_nxt;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected wire dibits are queued per frame
// and compared against rmii_txd by a negedge monitor.
module tb_eth_tx_framer;

  logic       clk;
  logic       rst;
  logic [1:0] rmii_txd;
  logic       rmii_txen;
  logic       busy;
  logic       underrun;

  eth_tx_framer_if tx_if ();

  eth_tx_framer dut (
    .clk       (clk),
    .rst       (rst),
    .tx        (tx_if),
    .rmii_txd  (rmii_txd),
    .rmii_txen (rmii_txen),
    .busy      (busy),
    .underrun  (underrun)
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] wire_q[$];
  int         hi_q[$];
  int         lo_q[$];
  int         txen_cycles = 0;
  int         ready_pulses = 0;
  int         underrun_pulses = 0;
  int         run_len = 0;
  logic       prev_txen = 1'b0;
  bit         mon_on = 1'b0;
  logic [1:0] mon_d;
  logic [7:0] src_data [0:255];
  logic       src_last [0:255];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    if (c[0] ^ b) return (c >> 1) ^ 32'hEDB88320;
    return c >> 1;
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) r = crc_bit(r, b[i]);
    return r;
  endfunction

  // Monitor: pops the scoreboard on every transmitted dibit.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      checks++;
      if (rmii_txen) begin
        txen_cycles++;
        wire_q.push_back(rmii_txd);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wire_extra: rmii_txd=%b with txen high, required no dibit", rmii_txd);
        end else begin
          mon_d = exp_q.pop_front();
          if (rmii_txd !== mon_d) begin
            errors++;
            $display("FAIL wire_dibit: rmii_txd=%b at dibit %0d, required %b",
                     rmii_txd, wire_q.size() - 1, mon_d);
          end
        end
      end else if (rmii_txd !== 2'b00) begin
        errors++;
        $display("FAIL idle_txd: rmii_txd=%b with txen low, required 00", rmii_txd);
      end
      if (tx_if.tx_ready === 1'b1) ready_pulses++;
      if (underrun === 1'b1)       underrun_pulses++;
      if (rmii_txen !== prev_txen) begin
        if (prev_txen) hi_q.push_back(run_len);
        else           lo_q.push_back(run_len);
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_txen = rmii_txen;
    end
  end

  task automatic clear_stats();
    txen_cycles     = 0;
    ready_pulses    = 0;
    underrun_pulses = 0;
    run_len         = 0;
    prev_txen       = rmii_txen;
    wire_q.delete();
    hi_q.delete();
    lo_q.delete();
    exp_q.delete();
  endtask

  // Queue the expected wire image of src_data[first +: n].
  task automatic push_frame(input int first, input int n, input bit complete,
                            output logic [31:0] fcs_o);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [7:0]  b;
    int          tot = (complete && n < 60) ? 60 : n;
    for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? src_data[first + i] : 8'h00;
      for (int j = 0; j < 4; j++) exp_q.push_back(b[2*j +: 2]);
      c = crc_byte(c, b);
    end
    fcs_o = ~c;
    if (complete) for (int k = 0; k < 16; k++) exp_q.push_back(fcs_o[2*k +: 2]);
  endtask

  // Offer src bytes 0..n-1 on the stream, then drop tx_valid.
  task automatic drive_src(input int n);
    int budget;
    for (int i = 0; i < n; i++) begin
      tx_if.tx_data  = src_data[i];
      tx_if.tx_last  = src_last[i];
      tx_if.tx_valid = 1'b1;
      budget = 0;
      @(negedge clk);
      while (tx_if.tx_ready !== 1'b1 && budget < 300) begin
        @(negedge clk);
        budget++;
      end
      if (tx_if.tx_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: byte %0d tx_ready=%b, required 1", i, tx_if.tx_ready);
        tx_if.tx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    tx_if.tx_valid = 1'b0;
    tx_if.tx_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy=%b, required 0", name, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_src(input int n, input int mul, input int add);
    for (int i = 0; i < n; i++) begin
      src_data[i] = 8'((i * mul + add) & 255);
      src_last[i] = (i == n - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_last  = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks += 5;
    if (rmii_txd !== 2'b00)     begin errors++; $display("FAIL rst_txd: %b, required 00", rmii_txd); end
    if (rmii_txen !== 1'b0)     begin errors++; $display("FAIL rst_txen: %b, required 0", rmii_txen); end
    if (tx_if.tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: %b, required 0", tx_if.tx_ready); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: %b, required 0", busy); end
    if (underrun !== 1'b0)      begin errors++; $display("FAIL rst_underrun: %b, required 0", underrun); end
    rst = 1'b0;
    tx_if.tx_data  = 8'hFF;
    tx_if.tx_valid = 1'b1;
    repeat (45) @(negedge clk);
    checks++;
    if (rmii_txen !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_active: txen=%b busy=%b, required 1 1", rmii_txen, busy);
    end
    #3 rst = 1'b1;
    #1;
    checks += 5;
    if (rmii_txd !== 2'b00)     begin errors++; $display("FAIL async_rst_txd: %b, required 00", rmii_txd); end
    if (rmii_txen !== 1'b0)     begin errors++; $display("FAIL async_rst_txen: %b, required 0", rmii_txen); end
    if (tx_if.tx_ready !== 1'b0) begin errors++; $display("FAIL async_rst_ready: %b, required 0", tx_if.tx_ready); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL async_rst_busy: %b, required 0", busy); end
    if (underrun !== 1'b0)      begin errors++; $display("FAIL async_rst_underrun: %b, required 0", underrun); end
    tx_if.tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
  endtask

  task automatic test_one_byte();
    logic [31:0] f;
    clear_stats();
    src_data[0] = 8'hA5;
    src_last[0] = 1'b1;
    push_frame(0, 1, 1'b1, f);
    drive_src(1);
    wait_idle("one_byte");
    checks += 4;
    if (txen_cycles != 288)   begin errors++; $display("FAIL one_byte_len: %0d, required 288", txen_cycles); end
    if (ready_pulses != 1)    begin errors++; $display("FAIL one_byte_ready: %0d pulses, required 1", ready_pulses); end
    if (exp_q.size() != 0)    begin errors++; $display("FAIL one_byte_left: %0d dibits unsent, required 0", exp_q.size()); end
    if (underrun_pulses != 0) begin errors++; $display("FAIL one_byte_underrun: %0d, required 0", underrun_pulses); end
  endtask

  task automatic test_sixty();
    logic [31:0] f;
    logic [31:0] wf;
    logic [31:0] c = 32'hFFFFFFFF;
    int          base;
    clear_stats();
    fill_src(60, 1, 0);
    push_frame(0, 60, 1'b1, f);
    drive_src(60);
    wait_idle("sixty");
    checks += 3;
    if (txen_cycles != 288) begin errors++; $display("FAIL sixty_len: %0d, required 288", txen_cycles); end
    if (wire_q.size() != 288) begin
      errors++;
      $display("FAIL sixty_wire: %0d dibits, required 288", wire_q.size());
    end else begin
      base = wire_q.size() - 16;
      for (int k = 0; k < 16; k++) wf[2*k +: 2] = wire_q[base + k];
      if (wf !== f) begin errors++; $display("FAIL sixty_fcs: %h, required %h", wf, f); end
      for (int k = 32; k < wire_q.size(); k++) begin
        c = crc_bit(c, wire_q[k][0]);
        c = crc_bit(c, wire_q[k][1]);
      end
      if (c !== 32'hDEBB20E3) begin errors++; $display("FAIL sixty_residue: %h, required DEBB20E3", c); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f;
    clear_stats();
    fill_src(100, 3, 1);
    for (int i = 0; i < 20; i++) begin
      src_data[100 + i] = 8'((i * 11 + 5) & 255);
      src_last[100 + i] = (i == 19);
    end
    push_frame(0, 100, 1'b1, f);
    push_frame(100, 20, 1'b1, f);
    drive_src(120);
    wait_idle("b2b");
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left: %0d dibits unsent, required 0", exp_q.size()); end
    if (hi_q.size() != 2 || lo_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_runs: %0d high / %0d low runs, required 2 / 2", hi_q.size(), lo_q.size());
    end else begin
      checks += 3;
      if (hi_q[0] != 448) begin errors++; $display("FAIL b2b_len1: %0d, required 448", hi_q[0]); end
      if (lo_q[1] != 48)  begin errors++; $display("FAIL b2b_gap: %0d, required 48", lo_q[1]); end
      if (hi_q[1] != 288) begin errors++; $display("FAIL b2b_len2: %0d, required 288", hi_q[1]); end
    end
  endtask

  task automatic test_underrun();
    logic [31:0] f;
    int          n = 0;
    clear_stats();
    fill_src(20, 5, 9);
    push_frame(0, 9, 1'b0, f);
    drive_src(9);
    while (tx_if.tx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks += 2;
    if (underrun !== 1'b1)  begin errors++; $display("FAIL ur_pulse: underrun=%b, required 1", underrun); end
    if (rmii_txen !== 1'b0) begin errors++; $display("FAIL ur_txen: txen=%b, required 0", rmii_txen); end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks += 4;
    if (n != 48)              begin errors++; $display("FAIL ur_ifg: busy for %0d cycles, required 48", n); end
    if (underrun_pulses != 1) begin errors++; $display("FAIL ur_count: %0d pulses, required 1", underrun_pulses); end
    if (ready_pulses != 10)   begin errors++; $display("FAIL ur_ready: %0d pulses, required 10", ready_pulses); end
    if (exp_q.size() != 0)    begin errors++; $display("FAIL ur_left: %0d dibits unsent, required 0", exp_q.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_crc_reinit();
    logic [31:0] f;
    logic [31:0] w [0:1];
    int          base;
    for (int r = 0; r < 2; r++) begin
      clear_stats();
      fill_src(64, 7, 3);
      push_frame(0, 64, 1'b1, f);
      drive_src(64);
      wait_idle("reinit");
      w[r] = '0;
      if (wire_q.size() >= 16) begin
        base = wire_q.size() - 16;
        for (int k = 0; k < 16; k++) w[r][2*k +: 2] = wire_q[base + k];
      end
      checks++;
      if (w[r] !== f) begin errors++; $display("FAIL reinit_fcs%0d: %h, required %h", r, w[r], f); end
    end
    checks++;
    if (w[1] !== w[0]) begin errors++; $display("FAIL reinit_same: second %h, required %h", w[1], w[0]); end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_sixty();
    test_back_to_back();
    test_underrun();
    test_crc_reinit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

RMII transmit framer for the 100 Mb/s Ethernet path. It accepts frame bytes from the MAC client over a valid/ready byte stream and emits the full frame on the RMII dibit interface. The frame is preamble, SFD, payload, zero padding to 60 bytes, a 32-bit FCS, then the inter-packet gap. The FCS comes from an instantiated `crc_gen` (2-bit, reflected CRC-32), which is fed the same dibits that go onto the wire.

## Interface
No parameters. All timing is fixed for RMII at 100 Mb/s: one dibit per `clk`, `clk` = 50 MHz.
- `clk`  in  1  RMII reference clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tx_data`  in  8  payload byte, bit 0 is transmitted first
- `tx_valid`  in  1  `tx_data`/`tx_last` valid; held high in IDLE starts a frame
- `tx_last`  in  1  accepted byte is the final payload byte
- `tx_ready`  out  1  byte accepted on an edge where `tx_valid && tx_ready`
- `rmii_txd`  out  2  transmit dibit, `[0]` first on wire
- `rmii_txen`  out  1  transmit enable
- `busy`  out  1  high in every state except IDLE
- `underrun`  out  1  one-cycle pulse when a frame is aborted

## Operation
- States: IDLE, PRE, DATA, PAD, FCS, IFG.
- `cnt` is a 6-bit cycle counter. `idx` is a 2-bit dibit index. `nbytes` counts payload plus pad bytes and saturates at 60. `sreg` is the 8-bit current-byte register. `fcs` is a 32-bit register. `last_q` is the registered `tx_last` of the current byte.
- IDLE
  - `tx_ready` = 0.
  - If `tx_valid` = 1, go to PRE with `cnt` = 0. The byte is not consumed yet.
- PRE: 32 cycles.
  - `rmii_txd` = 2'b01 for `cnt` 0..30 and 2'b11 at `cnt` = 31. This is 7×0x55 followed by 0xD5, LSB first.
  - `tx_ready` = 1 only at `cnt` = 31.
  - If the byte is accepted: load `sreg`, `last_q` and `nbytes` = 1, then go to DATA with `idx` = 0.
  - If no byte is accepted, go to ABORT handling.
- DATA
  - `rmii_txd` = `sreg[2*idx+1 : 2*idx]`.
  - At `idx` = 3 with `last_q` = 0: `tx_ready` = 1. An accepted byte reloads `sreg`, and `nbytes` increments. If no byte is accepted, go to ABORT handling.
  - At `idx` = 3 with `last_q` = 1: `tx_ready` = 0. Go to PAD if `nbytes` < 60, otherwise to FCS.
- PAD
  - Transmit 0x00 bytes (four 2'b00 dibits each) and increment `nbytes` per byte.
  - After the dibit `idx` = 3 of the byte that brings `nbytes` to 60, go to FCS.
- CRC feed
  - `crc_gen.data_in` = the current `rmii_txd` value.
  - `crc_en` = 1 in DATA and PAD only.
  - `crc_gen.rst` = `rst | crc_clr`. `crc_clr` is a flop: 1 in IDLE and IFG, 0 in PRE, DATA, PAD and FCS. It must be glitch-free and never combinational.
- FCS capture: on the final dibit of the final byte (DATA or PAD), load `fcs` ← `crc_out`.
- FCS state: 16 cycles, `cnt` 0..15, `rmii_txd` = `fcs[2*cnt+1 : 2*cnt]`. Then go to IFG.
- IFG: 48 cycles with `rmii_txen` = 0 and `rmii_txd` = 0, then go to IDLE.
- ABORT handling (underrun)
  - Go to IFG with `cnt` = 0, and pulse `underrun` for one cycle.
  - `rmii_txen` drops on the next edge and no FCS is sent, so the receiver sees a bad frame.
- Output rules
  - `rmii_txen` = 1 exactly in PRE, DATA, PAD and FCS.
  - `rmii_txd` = 0 whenever `rmii_txen` = 0.
  - Outputs are driven from registered state only; there is no combinational path from inputs to `rmii_txd`/`rmii_txen`.
  - `tx_ready` is decoded from state, `cnt`, `idx` and `last_q` only, never from `tx_valid`.

## Timing
- Reset values: state IDLE, `rmii_txd` = 0, `rmii_txen` = 0, `tx_ready` = 0, `busy` = 0, `underrun` = 0, all counters 0, `crc_clr` = 1.
- Reset mid-frame: all outputs return immediately to reset values, and the `crc_gen` register is forced to all-ones.
- Start latency: `tx_valid` sampled high in IDLE at edge k gives `rmii_txen` = 1 from edge k.
- The first payload dibit appears 32 cycles after `rmii_txen` rises.
- Byte acceptance: exactly one `tx_ready` cycle per byte, every 4 cycles during DATA.
  - The byte accepted at edge e has its first dibit on `rmii_txd` from edge e.
  - A source that keeps `tx_valid` high never underruns.
- Frame length on the wire: `rmii_txen` high for 4·(8 + max(N, 60) + 4) cycles for N payload bytes.
- Frame-to-frame spacing: minimum 48 cycles between `rmii_txen` falling and rising again. A frame can start on the first IDLE cycle after IFG.
- `tx_last` is ignored unless the byte is accepted.
- `nbytes` saturates at 60; there is no maximum-length check.

## Test plan
- Reset: assert `rst` asynchronously mid-DATA → all outputs 0 within the same cycle, `busy` = 0. After release, a 1-byte frame transmits correctly.
- 1-byte frame (0xA5, `tx_last` = 1)
  - 31×01 then 11 on `rmii_txd`.
  - Then dibits 01, 01, 10, 10.
  - Then 59 zero bytes, then 16 FCS dibits, with `rmii_txen` high 288 cycles total.
  - `tx_ready` pulses exactly once.
- 60-byte frame of bytes 0..59
  - No PAD state.
  - `rmii_txen` high 288 cycles.
  - FCS bytes equal the software CRC-32 of the payload, LSB first.
  - The CRC-32 register recomputed over payload plus FCS leaves residue 0xDEBB20E3.
- 100-byte frame with back-to-back second frame, `tx_valid` held → `rmii_txen` high 448 cycles, low exactly 48 cycles, then the second preamble begins.
- Underrun: drop `tx_valid` at the 10th `tx_ready`
  - `underrun` pulses once.
  - `rmii_txen` falls on the next edge.
  - 48 idle cycles follow, then `busy` = 0.
- CRC reinit: two identical 64-byte frames → identical FCS dibits in both.
